sdram_nios2_qsys_oci_dct_packer: RTL

- Producer side of the OCI data-compression-trace (DCT) word interface. Generates the 30-bit dct_buffer / 4-bit dct_count pair that the OCI trace consumer and test bench sample.
- Accepts 2-bit trace frames from the CPU trace source and packs up to 15 of them into one word. Each word is presented downstream with a valid/ready handshake.
- Double-buffered: an accumulator register plus an output holding register, so packing continues while a finished word waits.

---
 rtl/sdram_nios2_qsys_oci_dct_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sdram_nios2_qsys_oci_dct_packer.sv
// OCI DCT word packer: packs FRAME_W-bit trace frames into DEPTH-frame words behind a
// valid/ready output register. Optional macro SDRAM_NIOS2_QSYS_DCT_DROP_COUNT_EN drops frames instead of stalling.
module sdram_nios2_qsys_oci_dct_packer #(
  parameter int FRAME_W = 2,
  parameter int DEPTH   = 15,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_valid,
  input  logic [FRAME_W-1:0]         frame_data,
  output logic                       frame_ready,
  input  logic                       flush,
  input  logic                       word_ready,
  output logic                       word_valid,
  output logic [FRAME_W*DEPTH-1:0]   dct_buffer,
  output logic [CNT_W-1:0]           dct_count,
`ifdef SDRAM_NIOS2_QSYS_DCT_DROP_COUNT_EN
  output logic [15:0]                drop_count,
`endif
  output logic                       flush_busy
);
  localparam int BUF_W = FRAME_W * DEPTH;

  logic [BUF_W-1:0] acc_q, acc_d, buf_q, buf_d, merged;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_q, cnt_d, eff_cnt;
  logic             valid_q, valid_d, flush_busy_q, flush_busy_d;
  logic             out_free, acc_full, can_accept, accept, flush_req;

  always_comb begin
    out_free   = !valid_q || word_ready;
    acc_full   = (acc_cnt_q == CNT_W'(DEPTH));
    can_accept = !acc_full || out_free;
    accept     = frame_valid && can_accept;
    flush_req  = flush || flush_busy_q;

    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q && !word_ready;
    flush_busy_d = flush_busy_q;
    merged       = acc_q;
    eff_cnt      = acc_cnt_q;

    if (acc_full) begin
      if (out_free) begin
        // Stalled full word leaves; a new frame starts the cleared accumulator.
        buf_d        = acc_q;
        cnt_d        = acc_cnt_q;
        valid_d      = 1'b1;
        flush_busy_d = 1'b0;
        acc_d        = '0;
        acc_cnt_d    = '0;
        if (accept) begin
          acc_d[FRAME_W-1:0] = frame_data;
          acc_cnt_d          = CNT_W'(1);
        end
      end else begin
        flush_busy_d = flush_req;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (acc_cnt_q == CNT_W'(i)) merged[i*FRAME_W +: FRAME_W] = frame_data;
        end
        eff_cnt = acc_cnt_q + CNT_W'(1);
      end
      if (out_free && ((eff_cnt == CNT_W'(DEPTH)) || (flush_req && eff_cnt != '0))) begin
        buf_d        = merged;
        cnt_d        = eff_cnt;
        valid_d      = 1'b1;
        flush_busy_d = 1'b0;
        acc_d        = '0;
        acc_cnt_d    = '0;
      end else begin
        acc_d        = merged;
        acc_cnt_d    = eff_cnt;
        flush_busy_d = flush_req && (eff_cnt != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_busy_q <= flush_busy_d;
    end
  end

`ifdef SDRAM_NIOS2_QSYS_DCT_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (frame_valid && !can_accept && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count  = drop_q;
  assign frame_ready = 1'b1;
`else
  assign frame_ready = can_accept;
`endif

  assign word_valid = valid_q;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign flush_busy = flush_busy_q;
endmodule
